swizzle_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered bit-reverse (swizzle) unit among `NUM_REQ` requesters. It accepts one request per cycle over valid/ready handshakes and supports multi-beat locked bursts. It returns each result tagged with the requester index through a single back-pressurable response port. It sits between microbenchmark traffic generators and the swizzle datapath, so several stimulus sources can exercise one unit.

---
 rtl/swizzle_share_arbiter_if.sv | 58 +++++
 rtl/swizzle_share_arbiter.sv | 152 +++++++++++++++
 tb/tb_swizzle_share_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/swizzle_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// swizzle_share_arbiter_if
//
// Purpose: bundles the request and response handshakes of the shared swizzle
// arbiter so the requester side and the arbiter side connect through a single
// port each.
//
// Signals:
//   req_valid  [NUM_REQ]        per-requester request valid
//   req_last   [NUM_REQ]        per-requester "this beat ends the burst"
//   req_data   [NUM_REQ*WIDTH]  operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready  [NUM_REQ]        one-hot (or zero) accept from the arbiter
//   resp_valid                  result available in the output slot
//   resp_id    [IDW]            requester that issued the result
//   resp_data  [WIDTH]          bit-reversed operand
//   resp_ready                  consumer accepts the result
//
// Modports:
//   master - traffic generators plus result consumer
//   slave  - the arbiter itself
// ---------------------------------------------------------------------------
interface swizzle_share_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     resp_valid;
    logic [IDW-1:0]           resp_id;
    logic [WIDTH-1:0]         resp_data;
    logic                     resp_ready;

    modport master (
        output req_valid,
        output req_last,
        output req_data,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_id,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_last,
        input  req_data,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_id,
        output resp_data
    );
endinterface

// File: rtl/swizzle_share_arbiter.sv
// ---------------------------------------------------------------------------
// swizzle_share_arbiter
//
// Purpose: round-robin arbiter that shares one registered bit-reverse
// (swizzle) unit among NUM_REQ requesters. It accepts at most one beat per
// cycle and supports multi-beat locked bursts. Each result is tagged with the
// requester index and returned through a single back-pressurable output slot.
//
// Ports:
//   clock        single clock, all state updates on the rising edge
//   reset        synchronous, active-high; clears the slot, counter, pointer
//                and any locked burst
//   bus          slave side of swizzle_share_arbiter_if (request/response
//                handshakes)
//   grant_count  16-bit count of accepted beats since reset, wraps to 0
// ---------------------------------------------------------------------------
module swizzle_share_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    swizzle_share_arbiter_if.slave bus,
    output logic [15:0]            grant_count
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE_RR,
        LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     lock_q, lock_d;

    logic               resp_valid_q;
    logic [IDW-1:0]     resp_id_q;
    logic [WIDTH-1:0]   resp_data_q;
    logic [15:0]        count_q;

    logic               advance;
    logic               found;
    logic               accept;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     winner_inc;
    logic [IDW:0]       probe;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   swizzled;
    logic [NUM_REQ-1:0] ready_vec;

    // The slot can take a new result when it is empty or being drained now.
    assign advance = !resp_valid_q | bus.resp_ready;

    // Winner selection. While locked only the burst owner is considered, even
    // if it is idle, so a burst is never interleaved with other traffic.
    // Unlocked, search starts at ptr and wraps modulo NUM_REQ; probe carries
    // one extra bit so the wrap works for non-power-of-two NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        probe  = '0;
        if (state_q == LOCKED) begin
            winner = lock_q;
            found  = bus.req_valid[lock_q];
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                probe = {1'b0, ptr_q} + (IDW+1)'(k);
                if (probe >= (IDW+1)'(NUM_REQ)) begin
                    probe = probe - (IDW+1)'(NUM_REQ);
                end
                if (!found && bus.req_valid[probe[IDW-1:0]]) begin
                    winner = probe[IDW-1:0];
                    found  = 1'b1;
                end
            end
        end
    end

    // Reset suppresses acceptance so nothing is granted in the reset cycle.
    assign accept     = advance & found & !reset;
    assign winner_inc = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    assign operand    = bus.req_data[winner*WIDTH +: WIDTH];

    always_comb begin
        ready_vec = '0;
        if (accept) begin
            ready_vec[winner] = 1'b1;
        end
    end

    assign bus.req_ready = ready_vec;

    // Bit reversal of the selected operand.
    always_comb begin
        swizzled = '0;
        for (int b = 0; b < WIDTH; b++) begin
            swizzled[b] = operand[WIDTH-1-b];
        end
    end

    // Next-state logic. A beat with last=1 always releases the lock and moves
    // the pointer just past whoever was served; a non-last beat while unlocked
    // starts a burst and leaves the pointer untouched.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        if (accept) begin
            if (bus.req_last[winner]) begin
                ptr_d   = winner_inc;
                state_d = IDLE_RR;
            end else if (state_q == IDLE_RR) begin
                lock_d  = winner;
                state_d = LOCKED;
            end
        end
    end

    // State registers, output slot and grant counter. The slot reloads on an
    // accept (same-edge drain and refill), empties when drained with nothing
    // new, and otherwise holds still under back-pressure.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE_RR;
            ptr_q        <= '0;
            lock_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            count_q      <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            if (accept) begin
                resp_valid_q <= 1'b1;
                resp_id_q    <= winner;
                resp_data_q  <= swizzled;
                count_q      <= count_q + 16'd1;
            end else if (advance) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign grant_count    = count_q;

endmodule

// File: tb/tb_swizzle_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_swizzle_share_arbiter
//
// Purpose: directed self-checking bench for swizzle_share_arbiter with
// WIDTH=8, NUM_REQ=4. Expected values are hand-computed constants.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_swizzle_share_arbiter;
    logic        clock;
    logic        reset;
    logic [15:0] grant_count;

    int checks = 0;
    int errors = 0;

    logic [1:0] rr_id   [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [7:0] rr_data [6] = '{8'h80, 8'h40, 8'h80, 8'h10, 8'h80, 8'h40};

    swizzle_share_arbiter_if #(.WIDTH(8), .NUM_REQ(4)) bus ();

    swizzle_share_arbiter #(.WIDTH(8), .NUM_REQ(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .grant_count (grant_count)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Every comparison funnels through here so the counters stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic ready);
        bus.req_valid  = valid;
        bus.resp_ready = ready;
    endtask

    task automatic setLane(input int i, input logic [7:0] data, input logic last);
        bus.req_data[i*8 +: 8] = data;
        bus.req_last[i]        = last;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkSlot(input string tag, input logic [1:0] id,
                             input logic [7:0] data, input logic [15:0] count);
        checkOutput({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
        checkOutput({tag, "_id"},    32'(bus.resp_id),    32'(id));
        checkOutput({tag, "_data"},  32'(bus.resp_data),  32'(data));
        checkOutput({tag, "_count"}, 32'(grant_count),    32'(count));
    endtask

    initial begin
        $display("[TB] start");
        // Reset with all requesters valid: nothing may be granted.
        reset = 1'b1;
        setLane(0, 8'h01, 1'b1);
        setLane(1, 8'h02, 1'b1);
        setLane(2, 8'h01, 1'b1);
        setLane(3, 8'h08, 1'b1);
        applyStimulus(4'b1111, 1'b1);
        step();
        step();
        checkOutput("reset_ready", 32'(bus.req_ready),  32'h0);
        checkOutput("reset_valid", 32'(bus.resp_valid), 32'h0);
        checkOutput("reset_id",    32'(bus.resp_id),    32'h0);
        checkOutput("reset_data",  32'(bus.resp_data),  32'h0);
        checkOutput("reset_count", 32'(grant_count),    32'h0);

        // Single beat from requester 2.
        reset = 1'b0;
        applyStimulus(4'b0100, 1'b1);
        #1;
        checkOutput("single_ready", 32'(bus.req_ready), 32'b0100);
        step();
        checkSlot("single", 2'd2, 8'h80, 16'd1);
        applyStimulus(4'b0000, 1'b1);
        step();
        checkOutput("drain_valid", 32'(bus.resp_valid), 32'h0);

        // Round-robin with everyone valid from ptr=0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        applyStimulus(4'b1111, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            checkSlot($sformatf("rr%0d", k), rr_id[k], rr_data[k], 16'(k + 1));
        end
        applyStimulus(4'b0000, 1'b1);

        // Locked burst from requester 1 with 0 and 3 contending; ptr set to 1.
        reset = 1'b1;
        step();
        reset = 1'b0;
        applyStimulus(4'b0001, 1'b1);
        step();
        setLane(0, 8'h03, 1'b1);
        setLane(3, 8'h10, 1'b1);
        setLane(1, 8'hF0, 1'b0);
        applyStimulus(4'b1011, 1'b1);
        #1;
        checkOutput("burst_ready0", 32'(bus.req_ready), 32'b0010);
        step();
        checkSlot("burst_b0", 2'd1, 8'h0F, 16'd2);
        setLane(1, 8'h0F, 1'b0);
        applyStimulus(4'b1001, 1'b1);
        #1;
        checkOutput("burst_owner_idle", 32'(bus.req_ready), 32'b0000);
        step();
        checkOutput("burst_gap_valid", 32'(bus.resp_valid), 32'h0);
        applyStimulus(4'b1011, 1'b1);
        #1;
        checkOutput("burst_ready1", 32'(bus.req_ready), 32'b0010);
        step();
        checkSlot("burst_b1", 2'd1, 8'hF0, 16'd3);
        setLane(1, 8'hA5, 1'b1);
        step();
        checkSlot("burst_b2", 2'd1, 8'hA5, 16'd4);
        applyStimulus(4'b1001, 1'b1);
        #1;
        checkOutput("after_burst_ready", 32'(bus.req_ready), 32'b1000);
        step();
        checkSlot("after_burst_r3", 2'd3, 8'h08, 16'd5);
        checkOutput("after_r3_ready", 32'(bus.req_ready), 32'b0001);
        step();
        checkSlot("after_burst_r0", 2'd0, 8'hC0, 16'd6);

        // Back-pressure: pending id0/0x01 must freeze for 5 cycles.
        applyStimulus(4'b0000, 1'b1);
        step();
        setLane(0, 8'h80, 1'b1);
        setLane(1, 8'h02, 1'b1);
        applyStimulus(4'b0001, 1'b1);
        step();
        checkSlot("bp_load", 2'd0, 8'h01, 16'd7);
        applyStimulus(4'b0110, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput($sformatf("bp%0d_ready", k), 32'(bus.req_ready), 32'h0);
            step();
            checkSlot($sformatf("bp%0d", k), 2'd0, 8'h01, 16'd7);
        end
        applyStimulus(4'b0110, 1'b1);
        #1;
        checkOutput("bp_release_ready", 32'(bus.req_ready), 32'b0010);
        step();
        checkSlot("bp_release", 2'd1, 8'h40, 16'd8);

        // Reset in the middle of a 3-beat burst from requester 3 (ptr=2).
        setLane(3, 8'h10, 1'b0);
        applyStimulus(4'b1000, 1'b1);
        step();
        checkSlot("mid_b0", 2'd3, 8'h08, 16'd9);
        reset = 1'b1;
        setLane(0, 8'h03, 1'b1);
        applyStimulus(4'b1001, 1'b1);
        #1;
        checkOutput("mid_reset_ready", 32'(bus.req_ready), 32'h0);
        step();
        reset = 1'b0;
        checkOutput("mid_reset_valid", 32'(bus.resp_valid), 32'h0);
        checkOutput("mid_reset_count", 32'(grant_count),    32'h0);
        #1;
        checkOutput("post_reset_ready", 32'(bus.req_ready), 32'b0001);
        step();
        checkSlot("post_reset", 2'd0, 8'hC0, 16'd1);

        // Counter wrap after 65536 accepted beats.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            setLane(i, 8'h01, 1'b1);
        end
        applyStimulus(4'b1111, 1'b1);
        for (int n = 0; n < 65535; n++) begin
            step();
        end
        checkOutput("wrap_ffff", 32'(grant_count), 32'hFFFF);
        step();
        checkOutput("wrap_zero", 32'(grant_count), 32'h0);
        step();
        checkOutput("wrap_one",  32'(grant_count), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
